// File: rtl/jtag_probe_master.sv
// Host-side JTAG master: turns reset / IR-scan / DR-scan commands into TCK/TMS/TDI/TRST
// sequences and collects TDO. The TAP is always left in Run-Test/Idle between commands.
module jtag_probe_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = $clog2(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic              TRST
);
  localparam int IDX_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0] T_RESET = 2'd0;
  localparam logic [1:0] T_IR    = 2'd1;
  localparam logic [1:0] T_DR    = 2'd2;

  typedef enum logic [2:0] {IDLE, RST_SEQ, PRE, SHIFT, POST, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, last_idx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic                start_q, start_d, synced_q, synced_d;
  logic [1:0]          type_q, type_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d, rsp_q, rsp_d;
  logic                load;

  assign cmd_ready = (state_q == IDLE) && RST;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign TRST      = trst_q && RST;

  always_comb begin
    last_idx = '0;
    case (state_q)
      RST_SEQ: last_idx = IDX_W'(5);
      PRE:     last_idx = (type_q == T_IR) ? IDX_W'(3) : IDX_W'(2);
      SHIFT:   last_idx = IDX_W'(len_q);
      POST:    last_idx = IDX_W'(1);
      default: last_idx = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    trst_d   = trst_q;
    start_d  = start_q;
    synced_d = synced_q;
    type_d   = type_q;
    len_d    = len_q;
    data_d   = data_q;
    rsp_d    = rsp_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          type_d = cmd_type;
          len_d  = cmd_len;
          data_d = cmd_data;
          rsp_d  = '0;
          idx_d  = '0;
          cnt_d  = '0;
          if (cmd_type == T_RESET) begin
            state_d = RST_SEQ;
            start_d = 1'b1;
          end else if (cmd_type == T_IR || cmd_type == T_DR) begin
            state_d = synced_q ? PRE : RST_SEQ;
            start_d = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: begin
        if (start_q) begin
          // one setup cycle so the first period gets a full low phase with TMS settled
          start_d = 1'b0;
          load    = 1'b1;
        end else if (!tck_q) begin
          if (cnt_q == CNT_LAST) begin
            tck_d = 1'b1;
            cnt_d = '0;
            if (state_q == SHIFT) rsp_d[idx_q[LEN_W-1:0]] = TDO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == CNT_LAST) begin
          tck_d = 1'b0;
          cnt_d = '0;
          if (idx_q == last_idx) begin
            idx_d = '0;
            case (state_q)
              RST_SEQ: begin
                synced_d = 1'b1;
                state_d  = (type_q == T_RESET) ? RESP : PRE;
              end
              PRE:     state_d = SHIFT;
              SHIFT:   state_d = POST;
              default: state_d = RESP;
            endcase
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          load = (state_d != RESP);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // TMS/TDI/TRST for the period that starts on this edge
    if (load) begin
      case (state_d)
        RST_SEQ: tms_d = (idx_d != IDX_W'(5));
        PRE:     tms_d = (type_q == T_IR) ? (idx_d < IDX_W'(2)) : (idx_d == '0);
        SHIFT:   tms_d = (idx_d == IDX_W'(len_q));
        POST:    tms_d = (idx_d == '0);
        default: tms_d = tms_q;
      endcase
      tdi_d  = (state_d == SHIFT) ? data_q[idx_d[LEN_W-1:0]] : 1'b0;
      trst_d = !((state_d == RST_SEQ) && (idx_d == '0));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      trst_q   <= 1'b1;
      start_q  <= 1'b0;
      synced_q <= 1'b0;
      type_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      trst_q   <= trst_d;
      start_q  <= start_d;
      synced_q <= synced_d;
      type_q   <= type_d;
      len_q    <= len_d;
      data_q   <= data_d;
      rsp_q    <= rsp_d;
    end
  end
endmodule

// File: tb/tb_jtag_probe_master.sv
// Directed bench for jtag_probe_master: TMS/TDI logged per TCK rise, TAP model behind TDO.
module tb_jtag_probe_master;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        TCK, TMS, TDI, TDO, TRST;
  logic        loop = 1'b1;
  logic        tap_tdo = 1'b0;

  int tests = 0, failed = 0;
  int cyc = 0, nr = 0, rsp_cnt = 0;
  logic tms_log [0:1023];
  logic tdi_log [0:1023];
  logic trst_log[0:1023];
  int   rise_cyc[0:1023];

  jtag_probe_master #(.CLK_DIV(2), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TRST(TRST));

  always #5 CLK = ~CLK;
  assign TDO = loop ? TDI : tap_tdo;

  always @(posedge CLK) cyc = cyc + 1;
  always @(negedge CLK) if (rsp_valid) rsp_cnt = rsp_cnt + 1;
  always @(posedge TCK) begin
    if (nr < 1024) begin
      tms_log[nr] = TMS; tdi_log[nr] = TDI; trst_log[nr] = TRST; rise_cyc[nr] = cyc;
    end
    nr = nr + 1;
  end

  // Reference TAP controller with a 32-bit DR; IR path only tracked for state
  localparam logic [3:0] TLR=0, RTI=1, SDR=2, CDR=3, SHDR=4, E1DR=5, PDR=6, E2DR=7, UDR=8,
                         SIR=9, CIR=10, SHIR=11, E1IR=12, PIR=13, E2IR=14, UIR=15;
  logic [3:0]  st = TLR;
  logic [31:0] dr = '0, upd = '0;
  localparam logic [31:0] CAP = 32'h12345678;
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction
  always @(posedge TCK or negedge TRST) begin
    if (!TRST) st <= TLR;
    else begin
      if (st == CDR)  dr  <= CAP;
      if (st == SHDR) dr  <= {TDI, dr[31:1]};
      if (st == UDR)  upd <= dr;
      st <= tap_next(st, TMS);
    end
  end
  always @(negedge TCK) tap_tdo <= (st == SHDR) ? dr[0] : 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_tms(input int b, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tms_log[b+i];
    return v;
  endfunction
  function automatic logic [63:0] pack_tdi(input int b, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tdi_log[b+i];
    return v;
  endfunction

  // Present a command until accepted; acc = cycle count right after the accepting edge
  task automatic send(input logic [1:0] t, input int len, input logic [31:0] d, output int acc);
    int k;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_type = t; cmd_len = 5'(len); cmd_data = d;
    for (k = 0; k < 100 && !cmd_ready; k++) @(negedge CLK);
    check("accept_timeout", {63'd0, cmd_ready}, 64'd1);
    @(posedge CLK); #1;
    acc = cyc;
    cmd_valid = 1'b0; cmd_data = '0;
  endtask

  task automatic wait_rsp(output int rc, output logic [31:0] rd, output int rdy_hi);
    logic to = 1'b1;
    rdy_hi = 0; rc = 0; rd = '0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (cmd_ready) rdy_hi++;
      if (rsp_valid) begin rc = cyc; rd = rsp_data; to = 1'b0; break; end
    end
    check("rsp_timeout", {63'd0, to}, 64'd0);
  endtask

  initial begin
    int acc, rc, rh, b, acc2;
    logic [31:0] rd;

    // reset state
    repeat (3) @(posedge CLK); #1;
    check("rst_ready", cmd_ready, 0); check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0); check("rst_tck", TCK, 0);
    check("rst_tms", TMS, 1); check("rst_tdi", TDI, 0); check("rst_trst", TRST, 0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("rel_ready", cmd_ready, 1); check("rel_trst", TRST, 1);

    // reset command
    b = nr;
    send(2'd0, 0, 32'hFFFF_FFFF, acc);
    wait_rsp(rc, rd, rh);
    check("r_periods", nr - b, 6);
    check("r_tms", pack_tms(b, 6), 64'h1F);
    check("r_tdi", pack_tdi(b, 6), 0);
    check("r_trst0", trst_log[b], 0);
    check("r_trst1", trst_log[b+1], 1);
    check("r_first_rise", rise_cyc[b] - acc, 3);
    check("r_period_len", rise_cyc[b+1] - rise_cyc[b], 4);
    check("r_rsp_time", rc - rise_cyc[b+5], 2);
    check("r_rsp_data", rd, 0);
    check("r_ready_low", rh, 0);
    check("r_tck_after", TCK, 0);
    check("r_tap_rti", st, RTI);

    // reserved command: immediate response, no TCK
    b = nr;
    send(2'd3, 5, 32'h1234, acc);
    wait_rsp(rc, rd, rh);
    check("rsv_periods", nr - b, 0);
    check("rsv_rsp_time", rc - acc, 0);
    check("rsv_rsp_data", rd, 0);

    // IR scan, 4 bits, loopback
    b = nr;
    send(2'd1, 3, 32'h5, acc);
    wait_rsp(rc, rd, rh);
    check("ir_periods", nr - b, 10);
    check("ir_tms", pack_tms(b, 10), 64'h183);
    check("ir_tdi", pack_tdi(b, 10), 64'h050);
    check("ir_rsp", rd, 32'h5);
    check("ir_tap_rti", st, RTI);

    // DR scan, 32 bits, against the TAP model
    loop = 1'b0;
    b = nr;
    send(2'd2, 31, 32'hDEADBEEF, acc);
    wait_rsp(rc, rd, rh);
    check("dr_periods", nr - b, 37);
    check("dr_tms", pack_tms(b, 37), 64'hC_0000_0001);
    check("dr_rsp", rd, 32'h12345678);
    check("dr_upd", upd, 32'hDEADBEEF);
    check("dr_tap_rti", st, RTI);
    check("dr_rsp_time", rc - rise_cyc[b+36], 2);
    loop = 1'b1;

    // back-to-back with cmd_valid held
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_len = 5'd7; cmd_data = 32'hA5;
    for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge CLK);
    @(posedge CLK); #1;
    cmd_type = 2'd1; cmd_len = 5'd3; cmd_data = 32'hC;
    wait_rsp(rc, rd, rh);
    check("bb1_ready_low", rh, 0);
    check("bb1_rsp", rd, 32'hA5);
    check("bb1_ready_in_resp", cmd_ready, 0);
    b = nr;
    @(negedge CLK);
    check("bb_ready_after", cmd_ready, 1);
    @(posedge CLK); #1;
    acc2 = cyc;
    cmd_valid = 1'b0; cmd_data = '0;
    check("bb2_accept_cyc", acc2 - rc, 2);
    wait_rsp(rc, rd, rh);
    check("bb2_periods", nr - b, 10);
    check("bb2_first_rise", rise_cyc[b] - acc2, 3);
    check("bb2_tdi", pack_tdi(b, 10), 64'h0C0);
    check("bb2_rsp", rd, 32'hC);

    // abort during the 5th shift bit
    b = nr;
    send(2'd2, 7, 32'hFF, acc);
    begin
      int k;
      for (k = 0; k < 200 && nr < b + 8; k++) @(negedge CLK);
      check("abort_wait", {63'd0, nr >= b + 8}, 64'd1);
    end
    rh = rsp_cnt;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check("ab_tck", TCK, 0); check("ab_tms", TMS, 1); check("ab_tdi", TDI, 0);
    check("ab_trst", TRST, 0); check("ab_rsp_valid", rsp_valid, 0);
    check("ab_ready", cmd_ready, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("ab_no_rsp", rsp_cnt - rh, 0);

    // unsynced 1-bit DR scan gets the reset preamble
    b = nr;
    send(2'd2, 0, 32'hFFFF_FFFF, acc);
    wait_rsp(rc, rd, rh);
    check("us_periods", nr - b, 12);
    check("us_tms", pack_tms(b, 12), 64'h65F);
    check("us_tdi", pack_tdi(b, 12), 64'h200);
    check("us_trst0", trst_log[b], 0);
    check("us_rsp", rd, 32'h1);
    check("us_tap_rti", st, RTI);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
